// File: rtl/seq_checker.sv
// Sequence checker: tracks a 3-bit state word {A,B,C}, locks after two consecutive
// successor steps, flags mismatches while locked. Define SEQ_CHECKER_GRAY_EN for a Gray-code successor.
module seq_checker (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       EN,
  output logic       LOCK,
  output logic       ERR,
  output logic       FAULT,
  output logic [3:0] ERR_CNT,
  output logic [2:0] EXP
);

  // state     | meaning
  // ST_SYNC   | hunting for two consecutive successor steps, mismatches not flagged
  // ST_LOCKED | following the sequence, each mismatch pulses ERR and is counted
  // ST_FAULT  | three consecutive mismatches seen; frozen until RESET
  typedef enum logic [1:0] {ST_SYNC, ST_LOCKED, ST_FAULT} state_t;

  state_t     state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [1:0] match_cnt_q, match_cnt_d;
  logic [1:0] bad_cnt_q, bad_cnt_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic       err_q, err_d;
  logic       lock_q, lock_d;
  logic       fault_q, fault_d;

  logic [2:0] abc;
  logic [2:0] nxt_prev;
  logic       match;

  function automatic logic [2:0] nxt(input logic [2:0] p);
`ifdef SEQ_CHECKER_GRAY_EN
    logic [2:0] r;
    case (p)
      3'd0:    r = 3'd1;
      3'd1:    r = 3'd3;
      3'd3:    r = 3'd2;
      3'd2:    r = 3'd6;
      3'd6:    r = 3'd7;
      3'd7:    r = 3'd5;
      3'd5:    r = 3'd4;
      default: r = 3'd0;
    endcase
    return r;
`else
    return p + 3'd1;
`endif
  endfunction

  assign abc      = {A, B, C};
  assign nxt_prev = nxt(prev_q);
  assign match    = (abc == nxt_prev);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_cnt_d = match_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = 1'b0;

    if (EN && state_q != ST_FAULT) begin
      prev_d = abc;
      case (state_q)
        ST_SYNC: begin
          if (!match) begin
            match_cnt_d = 2'd0;
          end else if (match_cnt_q == 2'd1) begin
            state_d     = ST_LOCKED;
            match_cnt_d = 2'd0;
            bad_cnt_d   = 2'd0;
          end else begin
            match_cnt_d = match_cnt_q + 2'd1;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            bad_cnt_d = 2'd0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 4'd15) err_cnt_d = err_cnt_q + 4'd1;
            bad_cnt_d = bad_cnt_q + 2'd1;
            // the third mismatch in a row is still reported before freezing
            if (bad_cnt_q == 2'd2) state_d = ST_FAULT;
          end
        end
        default: ;
      endcase
    end

    lock_d  = (state_d == ST_LOCKED);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_SYNC;
      prev_q      <= 3'd0;
      match_cnt_q <= 2'd0;
      bad_cnt_q   <= 2'd0;
      err_cnt_q   <= 4'd0;
      err_q       <= 1'b0;
      lock_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_cnt_q <= match_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      lock_q      <= lock_d;
      fault_q     <= fault_d;
    end
  end

  assign LOCK    = lock_q;
  assign ERR     = err_q;
  assign FAULT   = fault_q;
  assign ERR_CNT = err_cnt_q;
  assign EXP     = nxt_prev;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_seq_checker;

  logic       CLK = 1'b0;
  logic       RESET, A, B, C, EN;
  logic       LOCK, ERR, FAULT;
  logic [3:0] ERR_CNT;
  logic [2:0] EXP;

  int errors = 0;
  int checks = 0;

  seq_checker dut (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .C(C), .EN(EN),
    .LOCK(LOCK), .ERR(ERR), .FAULT(FAULT), .ERR_CNT(ERR_CNT), .EXP(EXP)
  );

  always #5 CLK = ~CLK;

  // model: mode 0 = hunting, 1 = locked, 2 = faulted
  int m_mode, m_prev, m_run, m_bad, m_cnt, m_err, m_abc, m_hit;
  bit m_valid = 0;

  function automatic int m_nxt(input int p);
`ifdef SEQ_CHECKER_GRAY_EN
    int order [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    for (int i = 0; i < 8; i++)
      if (order[i] == p) return order[(i + 1) % 8];
    return 0;
`else
    return (p + 1) % 8;
`endif
  endfunction

  always @(posedge CLK) begin
    m_abc = {A, B, C};
    m_err = 0;
    if (RESET) begin
      m_mode = 0; m_prev = 0; m_run = 0; m_bad = 0; m_cnt = 0; m_valid = 1;
    end else if (EN && m_mode != 2) begin
      m_hit  = (m_abc == m_nxt(m_prev)) ? 1 : 0;
      m_prev = m_abc;
      if (m_mode == 0) begin
        m_run = m_hit ? m_run + 1 : 0;
        if (m_run == 2) begin m_mode = 1; m_run = 0; m_bad = 0; end
      end else if (m_hit) begin
        m_bad = 0;
      end else begin
        m_err = 1;
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        m_bad = m_bad + 1;
        if (m_bad == 3) m_mode = 2;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (m_valid) begin
      cmp("model_LOCK", int'(LOCK), (m_mode == 1) ? 1 : 0);
      cmp("model_FAULT", int'(FAULT), (m_mode == 2) ? 1 : 0);
      cmp("model_ERR", int'(ERR), m_err);
      cmp("model_ERR_CNT", int'(ERR_CNT), m_cnt);
      cmp("model_EXP", int'(EXP), m_nxt(m_prev));
    end
  end

  task automatic cyc(input int abc, input bit en, input bit rst);
    {A, B, C} = 3'(abc);
    EN = en;
    RESET = rst;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic chk_all(input string name, input int lk, input int er, input int ft, input int cnt, input int ex);
    cmp({name, "_LOCK"}, int'(LOCK), lk);
    cmp({name, "_ERR"}, int'(ERR), er);
    cmp({name, "_FAULT"}, int'(FAULT), ft);
    cmp({name, "_ERR_CNT"}, int'(ERR_CNT), cnt);
    cmp({name, "_EXP"}, int'(EXP), ex);
  endtask

  initial begin
    int p;
    int bad;
    RESET = 1'b1; EN = 1'b0; A = 1'b0; B = 1'b0; C = 1'b0;

`ifndef SEQ_CHECKER_GRAY_EN
    do_reset(2);
    chk_all("reset", 0, 0, 0, 0, 1);
    cyc(0, 1, 0); chk_all("acq0", 0, 0, 0, 0, 1);
    cyc(1, 1, 0); chk_all("acq1", 0, 0, 0, 0, 2);
    cyc(2, 1, 0); chk_all("acq2", 1, 0, 0, 0, 3);
    cyc(3, 1, 0); chk_all("acq3", 1, 0, 0, 0, 4);

    cyc(5, 1, 0); chk_all("skip", 1, 1, 0, 1, 6);
    cyc(6, 1, 0); chk_all("resume", 1, 0, 0, 1, 7);

    do_reset(1);
    cyc(3, 1, 0); cyc(4, 1, 0); cyc(5, 1, 0);
    chk_all("relock", 1, 0, 0, 0, 6);
    cyc(6, 1, 0); cmp("wrap6_ERR", int'(ERR), 0);
    cyc(7, 1, 0); cmp("wrap7_ERR", int'(ERR), 0);
    cyc(0, 1, 0); chk_all("wrap0", 1, 0, 0, 0, 1);
    cyc(1, 1, 0); chk_all("wrap1", 1, 0, 0, 0, 2);

    for (int i = 0; i < 5; i++) begin
      cyc($urandom_range(0, 7), 0, 0);
      chk_all("hold", 1, 0, 0, 0, 2);
    end
    cyc(2, 1, 0); chk_all("hold_exit", 1, 0, 0, 0, 3);

    p = 2;
    for (int i = 0; i < 16; i++) begin
      bad = (p + 4) % 8;
      cyc(bad, 1, 0);
      p = (bad + 1) % 8;
      cyc(p, 1, 0);
    end
    chk_all("sat", 1, 0, 0, 15, (p + 1) % 8);
    cyc((p + 4) % 8, 1, 0);
    chk_all("sat_more", 1, 1, 0, 15, (p + 5) % 8);

    do_reset(1);
    cyc(6, 1, 0); cyc(7, 1, 0); cyc(0, 1, 0);
    chk_all("f_lock", 1, 0, 0, 0, 1);
    cyc(0, 1, 0); chk_all("f_bad1", 1, 1, 0, 1, 1);
    cyc(0, 1, 0); chk_all("f_bad2", 1, 1, 0, 2, 1);
    cyc(0, 1, 0); chk_all("f_bad3", 0, 1, 1, 3, 1);
    for (int i = 0; i < 4; i++) begin
      cyc($urandom_range(0, 7), 1, 0);
      chk_all("f_sticky", 0, 0, 1, 3, 1);
    end
    do_reset(1);
    chk_all("f_cleared", 0, 0, 0, 0, 1);

    cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0);
    chk_all("mid_lock", 1, 0, 0, 0, 3);
    cyc(7, 1, 1);
    chk_all("mid_reset", 0, 0, 0, 0, 1);
`else
    do_reset(2);
    chk_all("g_reset", 0, 0, 0, 0, 1);
    cyc(0, 1, 0); cyc(1, 1, 0);
    cyc(3, 1, 0); chk_all("g_lock", 1, 0, 0, 0, 2);
    cyc(2, 1, 0); chk_all("g_follow", 1, 0, 0, 0, 6);
    do_reset(1);
    cyc(0, 1, 0); cyc(1, 1, 0);
    cyc(2, 1, 0); chk_all("g_binary", 0, 0, 0, 0, 6);
`endif

    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      int v;
      if ($urandom_range(0, 99) < 75) v = m_nxt(m_prev);
      else v = $urandom_range(0, 7);
      cyc(v, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 149) == 0));
    end

    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 The block SHALL use CLK, input, 1 bit, as its single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL use RESET, input, 1 bit, as its reset; reset is synchronous and active-high.
REQ-003 The block SHALL have input A, 1 bit, the MSB of the monitored 3-bit state word.
REQ-004 The block SHALL have input B, 1 bit, the middle bit of the monitored state word.
REQ-005 The block SHALL have input C, 1 bit, the LSB of the monitored state word; abc = {A,B,C}.
REQ-006 The block SHALL have input EN, 1 bit, the sample enable; abc is sampled only on edges where EN=1.
REQ-007 The block SHALL have output LOCK, 1 bit, asserted while the FSM is in LOCKED.
REQ-008 The block SHALL have output ERR, 1 bit, a one-cycle pulse per detected mismatch in LOCKED.
REQ-009 The block SHALL have output FAULT, 1 bit, asserted while the FSM is in FAULT.
REQ-010 The block SHALL have output ERR_CNT, 4 bits, the saturating total count of mismatches.
REQ-011 The block SHALL have output EXP, 3 bits, the expected next abc value.

Function
REQ-012 The block SHALL hold a prev register, 3 bits, and define nxt(prev) = (prev+1) mod 8 (7 wraps to 0).
REQ-013 On each EN=1 edge, match SHALL be (abc == nxt(prev)), and prev SHALL be loaded with abc in every state except FAULT.
REQ-014 The FSM SHALL have three states: SYNC, LOCKED and FAULT.
REQ-015 In SYNC, the FSM SHALL count consecutive matches (0..2) without flagging mismatches, which reset the count to 0; at the 2nd consecutive match it SHALL move to LOCKED.
REQ-016 In LOCKED, a match SHALL clear the consecutive-error count (0..3).
REQ-017 In LOCKED, a mismatch SHALL pulse ERR on the next cycle, increment ERR_CNT (saturating at 15) and increment the consecutive-error count.
REQ-018 In LOCKED, the 3rd consecutive mismatch SHALL move the FSM to FAULT on that same edge, with ERR also pulsed for it.
REQ-019 FAULT SHALL be sticky until RESET: EN ignored, prev/ERR_CNT frozen, ERR=0.
REQ-020 When EN=0, the block SHALL hold all state and counters, drive ERR=0, and ignore abc changes.
REQ-021 All outputs SHALL be registered; any flag caused by the sample on edge n SHALL be visible after edge n.
REQ-022 EXP SHALL equal nxt(prev) continuously from the registered prev.
REQ-023 ERR_CNT SHALL remain at 15 on further mismatches.

Reset
REQ-024 On RESET=1 at an edge, the block SHALL load FSM=SYNC, prev=0, match and error counts=0, ERR_CNT=0, LOCK=0, ERR=0 and FAULT=0.
REQ-025 RESET SHALL take priority over EN and any state, including FAULT; a mid-operation reset takes effect on that edge and discards the in-flight sample.
REQ-026 After reset, EXP SHALL read 1.

Configuration
REQ-027 The block SHALL support the macro SEQ_CHECKER_GRAY_EN.
REQ-028 With SEQ_CHECKER_GRAY_EN defined, nxt(prev) SHALL be the 3-bit reflected Gray successor (0,1,3,2,6,7,5,4, then 0); all FSM rules are unchanged.
REQ-029 With SEQ_CHECKER_GRAY_EN undefined, nxt(prev) SHALL be the binary successor of REQ-012.

Verification
REQ-030 The bench SHALL check: RESET 2 cycles, then EN=1 with abc=0,1,2,3 -> LOCK=0 after samples 0 and 1, LOCK=1 after sample 2, ERR never asserted.
REQ-031 The bench SHALL check: locked at prev=3, abc=5 -> ERR=1 for exactly one cycle, ERR_CNT=1, LOCK stays 1; then abc=6 -> match, no ERR.
REQ-032 The bench SHALL check: locked, three consecutive bad samples (abc=0,0,0 after prev=0) -> ERR_CNT=3, FAULT=1, LOCK=0; further EN activity leaves these unchanged until RESET, after which all outputs are 0 and EXP=1.
REQ-033 The bench SHALL check: locked, abc=6,7,0,1 -> 7->0 wrap accepted, ERR=0, EXP=2 after the final sample.
REQ-034 The bench SHALL check: locked, EN=0 for 5 cycles while abc toggles randomly -> ERR=0, ERR_CNT and EXP unchanged; then EN=1 with abc=EXP -> no error.
REQ-035 The bench SHALL check, with SEQ_CHECKER_GRAY_EN defined: abc=0,1,3,2 -> LOCK=1; abc=0,1,2 -> stays SYNC, LOCK=0, ERR=0.
